// File: rtl/fc_ctrl_pkg.sv
// Shared types and defaults for the fully-connected layer controller.
package fc_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_IN_DEF     = 16;
  localparam int unsigned NUM_OUT_DEF    = 10;
  localparam int unsigned ACC_LAT_DEF    = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_FEED    = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5,
    S_FINISH  = 3'd6
  } fc_state_e;

  // Address width for a given depth, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Control, memory-read, PE and result-write signals of the FC layer controller.
interface fc_layer_ctrl_if
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_IN     = NUM_IN_DEF,
  parameter int unsigned NUM_OUT    = NUM_OUT_DEF
);

  localparam int unsigned IN_AW  = addr_w(NUM_IN);
  localparam int unsigned W_AW   = addr_w(NUM_IN * NUM_OUT);
  localparam int unsigned OUT_AW = addr_w(NUM_OUT);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [IN_AW-1:0]      in_addr;
  logic [W_AW-1:0]       w_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] pe_input;
  logic [DATA_WIDTH-1:0] pe_weight;
  logic                  pe_clear;
  logic                  pe_valid;
  logic [DATA_WIDTH-1:0] pe_result;
  logic                  out_we;
  logic [OUT_AW-1:0]     out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  // Controller side.
  modport master (
    input  start, in_data, w_data, pe_result,
    output busy, done, in_addr, w_addr, pe_input, pe_weight,
           pe_clear, pe_valid, out_we, out_addr, out_data
  );

  // Environment side: memories, PE, output buffer and requester.
  modport slave (
    output start, in_data, w_data, pe_result,
    input  busy, done, in_addr, w_addr, pe_input, pe_weight,
           pe_clear, pe_valid, out_we, out_addr, out_data
  );

endinterface

// File: rtl/fc_layer_ctrl_lat_counter.sv
// Accumulator-latency wait counter: load, decrement to zero, zero/last flags.
module lat_counter #(
  parameter int unsigned LOAD_VAL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero_c,
  output logic last_c
);

  localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);
  assign last_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequences one FC layer: per neuron clear PE, feed NUM_IN operand pairs
// spaced by the accumulator latency, then write the accumulated result.
module fc_layer_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_IN     = NUM_IN_DEF,
  parameter int unsigned NUM_OUT    = NUM_OUT_DEF,
  parameter int unsigned ACC_LAT    = ACC_LAT_DEF
) (
  input logic             clk,
  input logic             reset,
  fc_layer_ctrl_if.master bus
);

  localparam int unsigned IN_AW  = addr_w(NUM_IN);
  localparam int unsigned W_AW   = addr_w(NUM_IN * NUM_OUT);
  localparam int unsigned OUT_AW = addr_w(NUM_OUT);

  fc_state_e             state, state_d;
  logic [IN_AW-1:0]      i_q, i_d;
  logic [OUT_AW-1:0]     n_q, n_d;

  logic                  cnt_load, cnt_dec, cnt_zero, cnt_last;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pe_clear_q, pe_clear_d;
  logic                  pe_valid_q, pe_valid_d;
  logic                  out_we_q, out_we_d;
  logic [IN_AW-1:0]      in_addr_q, in_addr_d;
  logic [W_AW-1:0]       w_addr_q, w_addr_d;
  logic [OUT_AW-1:0]     out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  lat_counter #(
    .LOAD_VAL (ACC_LAT)
  ) u_lat_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .zero_c (cnt_zero),
    .last_c (cnt_last)
  );

  // Next state, indices, and the registered output values for the next cycle.
  always_comb begin
    state_d    = state;
    n_d        = n_q;
    i_d        = i_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    in_addr_d  = in_addr_q;
    w_addr_d   = w_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = '0;
          i_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        i_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_FEED;
      end
      S_FEED: begin
        cnt_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_dec = !cnt_zero;
        if (cnt_last || cnt_zero) begin
          if (i_q != IN_AW'(NUM_IN - 1)) begin
            i_d     = i_q + IN_AW'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (n_q != OUT_AW'(NUM_OUT - 1)) begin
          n_d     = n_q + OUT_AW'(1);
          state_d = S_CLEAR;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    pe_clear_d = (state_d == S_CLEAR);
    pe_valid_d = (state_d == S_FEED);
    out_we_d   = (state_d == S_CAPTURE);

    if (state_d == S_ISSUE) begin
      in_addr_d = i_d;
      w_addr_d  = W_AW'(n_d) * W_AW'(NUM_IN) + W_AW'(i_d);
    end

    // pe_result has settled by the end of the last wait cycle.
    if (state_d == S_CAPTURE) begin
      out_addr_d = n_d;
      out_data_d = bus.pe_result;
    end
  end

  // State, indices and output registers; reset aborts any run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pe_clear_q <= 1'b0;
      pe_valid_q <= 1'b0;
      out_we_q   <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state      <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pe_clear_q <= pe_clear_d;
      pe_valid_q <= pe_valid_d;
      out_we_q   <= out_we_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pe_clear = pe_clear_q;
  assign bus.pe_valid = pe_valid_q;
  assign bus.out_we   = out_we_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;

  // Operands pass straight through while valid and read as zero otherwise.
  assign bus.pe_input  = pe_valid_q ? bus.in_data : '0;
  assign bus.pe_weight = pe_valid_q ? bus.w_data  : '0;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed scoreboard bench for fc_layer_ctrl with memory and PE models.
module tb_fc_layer_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned NI = 4;
  localparam int unsigned NO = 2;
  localparam int unsigned AL = 3;
  localparam int unsigned PD = AL - 1;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fc_layer_ctrl_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

  fc_layer_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_IN     (NI),
    .NUM_OUT    (NO),
    .ACC_LAT    (AL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total;
  int bad;
  int cyc;
  int done_cyc;
  int we_cyc[$];
  int we_data[$];
  int wtrace[$];
  sb_t sb[$];

  logic [31:0] in_mem [NI];
  logic [31:0] w_mem [NI*NO];

  // Small-integer float helpers (exact for the values used here).
  function automatic int f2int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] int2f(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 24; k++) if (v[k]) p = k;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int q_at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
  end

  // PE model: accumulate, result visible after the accumulator latency.
  int acc = 0;
  logic [31:0] pipe [PD];
  always @(posedge clk) begin
    if (bus.pe_clear) acc <= 0;
    else if (bus.pe_valid) acc <= acc + f2int(bus.pe_input) * f2int(bus.pe_weight);
    pipe[0] <= int2f(acc);
    for (int j = 1; j < PD; j++) pipe[j] <= pipe[j-1];
  end
  assign bus.pe_result = pipe[PD-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    sb_t e;
    int s;
    for (int n = 0; n < NO; n++) begin
      s = 0;
      for (int i = 0; i < NI; i++) s += f2int(in_mem[i]) * f2int(w_mem[n*NI+i]);
      e.addr = 8'(n);
      e.data = int2f(s);
      sb.push_back(e);
    end
  endtask

  task automatic fill(input int in_v, input int w_v, input bit ramp);
    for (int i = 0; i < NI; i++) in_mem[i] = int2f(ramp ? i + 1 : in_v);
    for (int k = 0; k < NI*NO; k++) w_mem[k] = int2f(ramp ? k + 1 : w_v);
  endtask

  // Per-cycle observation: exclusivity, operand order, result scoreboard.
  task automatic sample();
    sb_t e;
    int p;
    chk("mutex", 64'($countones({bus.pe_valid, bus.pe_clear, bus.out_we, bus.done}) <= 1), 64'd1);
    if (bus.pe_valid) begin
      wtrace.push_back(int'(bus.w_addr));
      p = (wtrace.size() - 1) % (NI*NO);
      chk("pe_input", 64'(bus.pe_input), 64'(in_mem[p % NI]));
      chk("pe_weight", 64'(bus.pe_weight), 64'(w_mem[p]));
    end
    if (bus.out_we) begin
      we_cyc.push_back(cyc);
      we_data.push_back(int'(bus.out_data));
      if (sb.size() == 0) begin
        chk("unexpected_we", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_addr", 64'(bus.out_addr), 64'(e.addr));
        chk("out_data", 64'(bus.out_data), 64'(e.data));
      end
    end
    if (bus.done && done_cyc == 0) done_cyc = cyc;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},     64'(bus.busy),      64'd0);
    chk({tag, "_done"},     64'(bus.done),      64'd0);
    chk({tag, "_pe_clear"}, 64'(bus.pe_clear),  64'd0);
    chk({tag, "_pe_valid"}, 64'(bus.pe_valid),  64'd0);
    chk({tag, "_out_we"},   64'(bus.out_we),    64'd0);
    chk({tag, "_in_addr"},  64'(bus.in_addr),   64'd0);
    chk({tag, "_w_addr"},   64'(bus.w_addr),    64'd0);
    chk({tag, "_out_addr"}, 64'(bus.out_addr),  64'd0);
    chk({tag, "_out_data"}, 64'(bus.out_data),  64'd0);
    chk({tag, "_pe_input"}, 64'(bus.pe_input),  64'd0);
  endtask

  // One layer run; cycle 1 is the first cycle after the start-sampling edge.
  task automatic run_layer(input int repulse_at, input int reset_at, input bit start_in_finish);
    we_cyc.delete();
    we_data.delete();
    wtrace.delete();
    done_cyc = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      cyc = c;
      sample();
      if (c == 1) chk("busy_after_start", 64'(bus.busy), 64'd1);
      if (c == reset_at + 1) begin
        check_zero_outputs("after_reset");
        reset = 1'b0;
      end
      if (bus.done) begin
        chk("busy_at_done", 64'(bus.busy), 64'd1);
        bus.start = start_in_finish;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = c + 1;
        sample();
        chk("idle_after_done", 64'(bus.busy), 64'd0);
        break;
      end
      bus.start = (c == repulse_at);
      if (c == reset_at) begin
        reset = 1'b1;
        sb.delete();
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_we_count"}, 64'(we_cyc.size()), 64'd2);
    chk({tag, "_we0_cyc"},  64'(q_at(we_cyc, 0)), 64'd22);
    chk({tag, "_we1_cyc"},  64'(q_at(we_cyc, 1)), 64'd44);
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'd45);
    chk({tag, "_sb_left"},  64'(sb.size()), 64'd0);
    chk({tag, "_wtrace_len"}, 64'(wtrace.size()), 64'(NI*NO));
    for (int k = 0; k < NI*NO; k++) chk({tag, "_wtrace"}, 64'(q_at(wtrace, k)), 64'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    done_cyc = 0;
    bus.start = 1'b0;
    fill(1, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Inputs 1.0, weights 2.0: both neurons give 8.0.
    push_expected();
    run_layer(-1, -1, 1'b0);
    check_timing("run1");
    chk("run1_data0", 64'(q_at(we_data, 0)), 64'(32'h41000000));
    chk("run1_data1", 64'(q_at(we_data, 1)), 64'(32'h41000000));

    // Ramp data, start re-pulsed mid-run and again in the FINISH cycle.
    fill(0, 0, 1'b1);
    push_expected();
    run_layer(10, -1, 1'b1);
    check_timing("run2");
    chk("run2_data0", 64'(q_at(we_data, 0)), 64'(32'h41F00000));
    chk("run2_data1", 64'(q_at(we_data, 1)), 64'(32'h428C0000));

    // Start in the IDLE cycle right after done, then abort by reset.
    push_expected();
    run_layer(-1, 15, 1'b0);
    chk("abort_we_count", 64'(we_cyc.size()), 64'd0);
    chk("abort_done", 64'(done_cyc), 64'd0);

    // Start coincident with reset stays idle.
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    chk("start_with_reset_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("start_with_reset_busy2", 64'(bus.busy), 64'd0);
    chk("start_with_reset_clear", 64'(bus.pe_clear), 64'd0);

    // Fresh run after the abort completes normally.
    fill(2, 3, 1'b0);
    push_expected();
    run_layer(-1, -1, 1'b0);
    check_timing("run3");
    chk("run3_data0", 64'(q_at(we_data, 0)), 64'(32'h41C00000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, IEEE-754 single-precision word width.
REQ-002 SHALL have parameter NUM_IN, default 16, inputs per neuron (≥2).
REQ-003 SHALL have parameter NUM_OUT, default 10, neurons in the layer (≥1).
REQ-004 SHALL have parameter ACC_LAT, default 4, cycles from pe_valid until the PE accumulator output is stable (≥1).
REQ-005 SHALL have clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have start  input  1  one-cycle request to run the layer.
REQ-008 SHALL have busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have done  output  1  one-cycle pulse when the last neuron is written.
REQ-010 SHALL have in_addr  output  clog2(NUM_IN)  input-buffer read address.
REQ-011 SHALL have w_addr  output  clog2(NUM_IN*NUM_OUT)  weight-memory read address.
REQ-012 SHALL have in_data, w_data  input  DATA_WIDTH  read data, valid one cycle after address.
REQ-013 SHALL have pe_input, pe_weight  output  DATA_WIDTH  operands to PE (pass-through of in_data/w_data).
REQ-014 SHALL have pe_clear  output  1  zeroes PE accumulator (drives start_FC).
REQ-015 SHALL have pe_valid  output  1  operands on pe_input/pe_weight are to be accumulated.
REQ-016 SHALL have pe_result  input  DATA_WIDTH  PE accumulator output.
REQ-017 SHALL have out_we  output  1, out_addr  output  clog2(NUM_OUT), out_data  output  DATA_WIDTH  result write port.

Function
REQ-018 SHALL implement states IDLE, CLEAR, ISSUE, FEED, WAIT, CAPTURE, FINISH.
REQ-019 IDLE: start=1 -> CLEAR with neuron index n=0, element index i=0; else stay.
REQ-020 CLEAR: pe_clear=1 for exactly one cycle, i=0 -> ISSUE.
REQ-021 ISSUE: drive in_addr=i, w_addr=n*NUM_IN+i for one cycle -> FEED.
REQ-022 FEED: pe_valid=1 for exactly one cycle with pe_input=in_data, pe_weight=w_data; load wait counter with ACC_LAT -> WAIT.
REQ-023 WAIT: decrement counter; at zero, if i<NUM_IN-1 then i++ -> ISSUE, else -> CAPTURE; no new operand enters the PE while waiting (accumulator feedback dependency).
REQ-024 CAPTURE: out_we=1, out_addr=n, out_data=pe_result for one cycle; if n<NUM_OUT-1 then n++ -> CLEAR, else -> FINISH.
REQ-025 FINISH: done=1 for one cycle -> IDLE.
REQ-026 Per-neuron time SHALL be NUM_IN*(ACC_LAT+2)+2 cycles; done SHALL assert NUM_OUT*(NUM_IN*(ACC_LAT+2)+2)+1 cycles after the edge sampling start.
REQ-027 start while busy SHALL be ignored (no queuing, no restart).
REQ-028 start in the FINISH cycle SHALL be ignored; start in IDLE the cycle after done SHALL be accepted.
REQ-029 Address arithmetic SHALL be unsigned, width-exact, no wrap within a run; i and n never exceed NUM_IN-1 / NUM_OUT-1.
REQ-030 pe_valid, pe_clear, out_we, done SHALL be mutually exclusive in any cycle.

Reset
REQ-031 reset=1 SHALL force IDLE on next edge, overriding start and any in-flight run.
REQ-032 Reset values: busy, done, pe_clear, pe_valid, out_we = 0; in_addr, w_addr, out_addr, out_data = 0; n, i, counter = 0.
REQ-033 A run aborted by reset SHALL produce no further out_we or done.

Structure
REQ-034 State encoding and default parameter constants SHALL live in shared package fc_ctrl_pkg.
REQ-035 The ACC_LAT wait counter SHALL be one sub-module, lat_counter (load, decrement, zero flag).

Verification
REQ-036 NUM_IN=4, NUM_OUT=2, ACC_LAT=3, start pulse -> out_we at cycles 22 and 44, done at cycle 45, out_addr 0 then 1.
REQ-037 Same config, inputs all 1.0, weights 2.0 -> out_data 32'h41000000 (8.0) for both neurons.
REQ-038 Same config, trace w_addr -> sequence 0,1,2,3,4,5,6,7, each issued once.
REQ-039 start re-pulsed at cycle 10 -> ignored, timing identical to REQ-036.
REQ-040 reset at cycle 15 -> all outputs 0 next cycle, no out_we/done; fresh start afterwards completes per REQ-036.
REQ-041 start coincident with reset -> stays IDLE, busy=0.
